// File: rtl/runner_pkg.sv
// Shared types and constants for the lane runner's per-frame player logic.
package runner_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    MID   = 2'd1,
    RIGHT = 2'd2
  } lane_t;

  typedef logic [11:0] offset_t;

  localparam offset_t GROUND = 12'd40;

  // Offsets are two's complement, so the distance is taken at 13 bits to avoid aliasing.
  function automatic logic [12:0] offset_dist(input offset_t a, input offset_t b);
    logic signed [12:0] d;
    d = $signed({a[11], a}) - $signed({b[11], b});
    return d[12] ? 13'(-d) : 13'(d);
  endfunction

endpackage

// File: rtl/collision_check.sv
// Lane/distance compare of the player against one obstacle, with a hit-event counter.
module collision_check
  import runner_pkg::*;
#(
  parameter int      OBST_LANE    = 1,
  parameter int      COUNT_WIDTH  = 32,
  parameter offset_t POS_MISMATCH = 12'd60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rst_count,
  input  logic                   is_jumping,
  input  logic [1:0]             player_lane,
  input  offset_t                pos,
  input  offset_t                obst_voffset,
  input  logic [OBST_LANE*2-1:0] obst_lane,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [OBST_LANE-1:0]   has_collision
);

  logic [OBST_LANE-1:0] hit;
  logic                 hit_prev;
  logic                 in_range;

  assign in_range = offset_dist(pos, obst_voffset) < {1'b0, POS_MISMATCH};

  always_comb begin
    hit = '0;
    for (int i = 0; i < OBST_LANE; i++) begin
      hit[i] = (obst_lane[2*i +: 2] == player_lane) && !is_jumping && in_range;
    end
  end

  // One obstacle pass spans several frames; only the rising edge of the combined hit counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      has_collision <= '0;
      count         <= '0;
      hit_prev      <= 1'b0;
    end else begin
      has_collision <= hit;
      if (rst_count) begin
        count    <= '0;
        hit_prev <= 1'b0;
      end else begin
        hit_prev <= |hit;
        if ((|hit) && !hit_prev) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/player_motion_collide.sv
// Per-frame player logic: jump arc on the vertical sprite offset plus obstacle collision detection.
module player_motion_collide #(
  parameter runner_pkg::offset_t GROUND       = runner_pkg::GROUND,
  parameter logic [5:0]          JUMP_VEL     = 6'd20,
  parameter logic [5:0]          GRAVITY      = 6'd2,
  parameter runner_pkg::offset_t POS_MISMATCH = 12'd60,
  parameter int                  OBST_LANE    = 1,
  parameter int                  COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   up,
  input  logic [11:0]            pos,
  output logic [11:0]            next_pos,
  output logic                   is_jumping,
  input  logic                   rst_count,
  input  logic [1:0]             player_lane,
  input  logic [11:0]            obst_voffset,
  input  logic [OBST_LANE*2-1:0] obst_lane,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [OBST_LANE-1:0]   has_collision
);

  localparam logic signed [6:0]  JUMP_V   = signed'({1'b0, JUMP_VEL});
  localparam logic signed [6:0]  GRAV_V   = signed'({1'b0, GRAVITY});
  localparam logic signed [12:0] GROUND_S = signed'({1'b0, GROUND});

  logic signed [6:0]  vel;
  logic signed [6:0]  vel_next;
  logic               jumping_next;
  logic signed [12:0] pos_s;
  logic signed [12:0] cand;

  // Launch frame already moves by JUMP_VEL, so the stored velocity starts one gravity step lower.
  always_comb begin
    pos_s        = signed'({pos[11], pos});
    cand         = pos_s - signed'({{6{vel[6]}}, vel});
    next_pos     = pos;
    vel_next     = vel;
    jumping_next = is_jumping;
    if (!is_jumping) begin
      if (up) begin
        next_pos     = pos - {6'd0, JUMP_VEL};
        vel_next     = JUMP_V - GRAV_V;
        jumping_next = 1'b1;
      end
    end else if ((cand >= GROUND_S) && (vel[6] || (vel == '0))) begin
      next_pos     = GROUND;
      vel_next     = '0;
      jumping_next = 1'b0;
    end else begin
      next_pos = cand[11:0];
      vel_next = vel - GRAV_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel        <= '0;
      is_jumping <= 1'b0;
    end else begin
      vel        <= vel_next;
      is_jumping <= jumping_next;
    end
  end

  collision_check #(
    .OBST_LANE    (OBST_LANE),
    .COUNT_WIDTH  (COUNT_WIDTH),
    .POS_MISMATCH (POS_MISMATCH)
  ) u_collision_check (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_count     (rst_count),
    .is_jumping    (is_jumping),
    .player_lane   (player_lane),
    .pos           (pos),
    .obst_voffset  (obst_voffset),
    .obst_lane     (obst_lane),
    .count         (count),
    .has_collision (has_collision)
  );

endmodule

// File: tb/tb_player_motion_collide.sv
// Randomized and directed bench for player_motion_collide against a closed-form jump/collision model.
module tb_player_motion_collide;

  localparam int GND = 40;
  localparam int JV  = 20;
  localparam int GR  = 2;
  localparam int PM  = 60;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        up;
  logic [11:0] pos;
  logic [11:0] next_pos;
  logic        is_jumping;
  logic        rst_count;
  logic [1:0]  player_lane;
  logic [11:0] obst_voffset;
  logic [1:0]  obst_lane;
  logic [31:0] count;
  logic [0:0]  has_collision;

  logic        up2;
  logic [11:0] pos2;
  logic [11:0] next_pos2;
  logic        is_jumping2;
  logic        rst_count2;
  logic [1:0]  player_lane2;
  logic [11:0] obst_voffset2;
  logic [3:0]  obst_lane2;
  logic [31:0] count2;
  logic [1:0]  has_collision2;

  player_motion_collide dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .up            (up),
    .pos           (pos),
    .next_pos      (next_pos),
    .is_jumping    (is_jumping),
    .rst_count     (rst_count),
    .player_lane   (player_lane),
    .obst_voffset  (obst_voffset),
    .obst_lane     (obst_lane),
    .count         (count),
    .has_collision (has_collision)
  );

  player_motion_collide #(.OBST_LANE(2)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .up            (up2),
    .pos           (pos2),
    .next_pos      (next_pos2),
    .is_jumping    (is_jumping2),
    .rst_count     (rst_count2),
    .player_lane   (player_lane2),
    .obst_voffset  (obst_voffset2),
    .obst_lane     (obst_lane2),
    .count         (count2),
    .has_collision (has_collision2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner-held pos, airborne flag, frames since launch.
  int          m_pos;
  bit          m_air;
  int          m_n;
  int          m_launch;
  bit          m_hcol;
  bit          m_prev;
  logic [31:0] m_count;

  logic [11:0] last_next;
  logic        last_hcol;
  logic [31:0] last_count;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, actual, actual, expected, expected, $time);
    end
  endtask

  function automatic int arc(input int launch, input int n);
    return launch - JV * n + (GR * n * (n - 1)) / 2;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One frame: compare against the model at the negedge, then advance model and owner pos at the posedge.
  task automatic applyStimulus();
    int          np;
    bit          air_n;
    int          n_n;
    bit          hit;
    int          ov;
    logic [11:0] e;
    @(negedge clk);
    checkOutput("is_jumping", {31'd0, is_jumping}, {31'd0, m_air});
    checkOutput("has_collision", {31'd0, has_collision}, {31'd0, m_hcol});
    checkOutput("count", count, m_count);
    np    = m_pos;
    air_n = m_air;
    n_n   = m_n;
    if (!m_air) begin
      if (up) begin
        air_n    = 1'b1;
        n_n      = 1;
        m_launch = m_pos;
        np       = arc(m_pos, 1);
      end
    end else begin
      n_n = m_n + 1;
      np  = arc(m_launch, n_n);
      if ((JV - GR * (n_n - 1) <= 0) && (np >= GND)) begin
        np    = GND;
        air_n = 1'b0;
      end
    end
    e = np[11:0];
    checkOutput("next_pos", {20'd0, next_pos}, {20'd0, e});
    last_next  = next_pos;
    last_hcol  = has_collision[0];
    last_count = count;
    ov  = int'($signed(obst_voffset));
    hit = (obst_lane == player_lane) && !m_air && (iabs(m_pos - ov) < PM);
    @(posedge clk);
    m_hcol = hit;
    if (rst_count) begin
      m_count = '0;
      m_prev  = 1'b0;
    end else begin
      if (hit && !m_prev) m_count = m_count + 1;
      m_prev = hit;
    end
    m_air = air_n;
    m_n   = n_n;
    m_pos = np;
    #1;
    pos = m_pos[11:0];
  endtask

  task automatic sweep(output int hits);
    int v;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      v = -140 + 32 * k;
      obst_voffset = v[11:0];
      applyStimulus();
      hits += int'(last_hcol);
    end
    obst_voffset = 12'd1024;
    applyStimulus();
    hits += int'(last_hcol);
  endtask

  task automatic clearCount();
    rst_count = 1'b1;
    obst_voffset = 12'd1024;
    applyStimulus();
    rst_count = 1'b0;
  endtask

  logic [11:0] jump_np [1:21];
  int          hits;
  int          ov;

  initial begin
    rst_n = 1'b0;
    up = 1'b0; pos = 12'd40; rst_count = 1'b0;
    player_lane = 2'd1; obst_voffset = 12'd1024; obst_lane = 2'd1;
    up2 = 1'b0; pos2 = 12'd40; rst_count2 = 1'b0;
    player_lane2 = 2'd2; obst_voffset2 = 12'd40; obst_lane2 = {2'd2, 2'd1};
    m_pos = GND; m_air = 1'b0; m_n = 0; m_launch = GND;
    m_hcol = 1'b0; m_prev = 1'b0; m_count = '0;

    #12;
    checkOutput("reset is_jumping", {31'd0, is_jumping}, 32'd0);
    checkOutput("reset count", count, 32'd0);
    checkOutput("reset has_collision2", {30'd0, has_collision2}, 32'd0);
    checkOutput("reset next_pos", {20'd0, next_pos}, 32'd40);
    #10;
    rst_n = 1'b1;

    // Idle on the ground
    for (int f = 0; f < 10; f++) applyStimulus();
    checkOutput("idle next_pos", {20'd0, last_next}, 32'd40);

    // Single jump from the ground
    up = 1'b1;
    applyStimulus();
    jump_np[1] = last_next;
    up = 1'b0;
    for (int f = 2; f <= 21; f++) begin
      applyStimulus();
      jump_np[f] = last_next;
    end
    checkOutput("jump f1", {20'd0, jump_np[1]}, 32'd20);
    checkOutput("jump f2", {20'd0, jump_np[2]}, 32'd2);
    checkOutput("jump f3", {20'd0, jump_np[3]}, 32'h0000_0ff2);
    checkOutput("jump peak", {20'd0, jump_np[10]}, 32'h0000_0fba);
    checkOutput("jump land", {20'd0, jump_np[21]}, 32'd40);
    checkOutput("landed", {31'd0, is_jumping}, 32'd0);

    // Lane match sweep
    clearCount();
    player_lane = 2'd1; obst_lane = 2'd1;
    sweep(hits);
    checkOutput("sweep hits", hits, 32'd4);
    checkOutput("sweep count", last_count, 32'd1);

    // Lane miss sweep
    clearCount();
    player_lane = 2'd0;
    sweep(hits);
    checkOutput("miss hits", hits, 32'd0);
    checkOutput("miss count", last_count, 32'd0);

    // Jump immunity sweep
    player_lane = 2'd1;
    up = 1'b1;
    applyStimulus();
    up = 1'b0;
    sweep(hits);
    checkOutput("airborne hits", hits, 32'd0);
    checkOutput("airborne count", last_count, 32'd0);
    for (int f = 0; f < 10; f++) applyStimulus();

    // Two-lane obstacle and count clear
    applyStimulus();
    checkOutput("two-lane hcol", {30'd0, has_collision2}, 32'd2);
    checkOutput("two-lane count", count2, 32'd1);
    rst_count2 = 1'b1;
    applyStimulus();
    rst_count2 = 1'b0;
    checkOutput("clear count2", count2, 32'd0);
    checkOutput("clear hcol2", {30'd0, has_collision2}, 32'd2);
    applyStimulus();
    checkOutput("recount count2", count2, 32'd1);

    // Reset mid-jump
    up = 1'b1;
    applyStimulus();
    up = 1'b0;
    for (int f = 0; f < 4; f++) applyStimulus();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midjump is_jumping", {31'd0, is_jumping}, 32'd0);
    checkOutput("midjump next_pos", {20'd0, next_pos}, {20'd0, pos});
    checkOutput("midjump pos airborne", {31'd0, (pos != 12'd40)}, 32'd1);
    checkOutput("midjump count2", count2, 32'd0);
    checkOutput("midjump hcol2", {30'd0, has_collision2}, 32'd0);
    checkOutput("midjump has_collision", {31'd0, has_collision}, 32'd0);
    m_air = 1'b0; m_n = 0; m_hcol = 1'b0; m_prev = 1'b0; m_count = '0;
    m_pos = GND;
    pos = 12'd40;
    #1;
    rst_n = 1'b1;

    // Randomized play
    for (int f = 0; f < 400; f++) begin
      up          = ($urandom_range(0, 7) == 0);
      player_lane = 2'($urandom_range(0, 2));
      obst_lane   = 2'($urandom_range(0, 2));
      rst_count   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) ov = int'($urandom_range(0, 600)) - 300;
      else ov = m_pos + int'($urandom_range(0, 160)) - 80;
      obst_voffset = ov[11:0];
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
